// File: rtl/clmul_unit.sv
// Sequential carry-less multiplier for CLMUL / CLMULH / CLMULR.
// Consumes BITS_PER_CYCLE multiplier bits per cycle with a shift-XOR accumulator.
module clmul_unit #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [1:0]  s_mode_i,
    input  logic [31:0] s_op1_i,
    input  logic [31:0] s_op2_i,
    input  logic        s_flush_i,
    output logic        s_valid_o,
    output logic [31:0] s_result_o,
    input  logic        s_ack_i
);

    localparam int N     = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [63:0]        mcand_q;
    logic [31:0]        mplier_q;
    logic [1:0]         mode_q;
    logic [63:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        result_q;
    logic               valid_q;

    logic [63:0]        acc_d;
    logic [31:0]        result_d;

    // mcand_q is pre-shifted by c*BITS_PER_CYCLE and mplier_q pre-shifted right by the
    // same amount, so bit k of mplier_q is op2[c*BITS_PER_CYCLE+k].
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                acc_d = acc_d ^ (mcand_q << k);
            end
        end
    end

    always_comb begin
        result_d = 32'h0;
        case (mode_q)
            2'b00:   result_d = acc_d[31:0];
            2'b01:   result_d = acc_d[63:32];
            2'b10:   result_d = acc_d[62:31];
            default: result_d = 32'h0;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q  <= IDLE;
            mcand_q  <= 64'h0;
            mplier_q <= 32'h0;
            mode_q   <= 2'b00;
            acc_q    <= 64'h0;
            cnt_q    <= '0;
            result_q <= 32'h0;
            valid_q  <= 1'b0;
        end else if (s_flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid_i) begin
                        mcand_q  <= {32'h0, s_op1_i};
                        mplier_q <= s_op2_i;
                        mode_q   <= s_mode_i;
                        acc_q    <= 64'h0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q  <= DONE;
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (s_ack_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o  = (state_q == IDLE);
    assign s_valid_o  = valid_q;
    assign s_result_o = result_q;

endmodule

// File: tb/tb_clmul_unit.sv
// Directed bench for clmul_unit: four instances at BITS_PER_CYCLE 4, 1, 2, 8.
// Instance 0 (default radix) carries the protocol tests.
module tb_clmul_unit;

    logic        clk;
    logic        resetn;
    logic [3:0]  valid_i;
    logic [3:0]  ack_i;
    logic [1:0]  mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic [3:0]  ready_o;
    logic [3:0]  valid_o;
    logic [31:0] result_o [4];

    int n_cmp;
    int n_err;

    clmul_unit #(.BITS_PER_CYCLE(4)) u_dut0 (
        .s_clk_i(clk), .s_resetn_i(resetn), .s_valid_i(valid_i[0]), .s_ready_o(ready_o[0]),
        .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2), .s_flush_i(flush),
        .s_valid_o(valid_o[0]), .s_result_o(result_o[0]), .s_ack_i(ack_i[0]));
    clmul_unit #(.BITS_PER_CYCLE(1)) u_dut1 (
        .s_clk_i(clk), .s_resetn_i(resetn), .s_valid_i(valid_i[1]), .s_ready_o(ready_o[1]),
        .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2), .s_flush_i(flush),
        .s_valid_o(valid_o[1]), .s_result_o(result_o[1]), .s_ack_i(ack_i[1]));
    clmul_unit #(.BITS_PER_CYCLE(2)) u_dut2 (
        .s_clk_i(clk), .s_resetn_i(resetn), .s_valid_i(valid_i[2]), .s_ready_o(ready_o[2]),
        .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2), .s_flush_i(flush),
        .s_valid_o(valid_o[2]), .s_result_o(result_o[2]), .s_ack_i(ack_i[2]));
    clmul_unit #(.BITS_PER_CYCLE(8)) u_dut3 (
        .s_clk_i(clk), .s_resetn_i(resetn), .s_valid_i(valid_i[3]), .s_ready_o(ready_o[3]),
        .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2), .s_flush_i(flush),
        .s_valid_o(valid_o[3]), .s_result_o(result_o[3]), .s_ack_i(ack_i[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int i, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        check($sformatf("u%0d_ready_before", i), 32'(ready_o[i]), 32'd1);
        mode = m; op1 = a; op2 = b;
        valid_i[i] = 1'b1;
        tick();
        valid_i[i] = 1'b0;
        mode = 2'b00; op1 = 32'hDEAD_BEEF; op2 = 32'hCAFE_F00D;
        check($sformatf("u%0d_accepted", i), 32'(ready_o[i]), 32'd0);
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (!valid_o[i] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_ack(input int i);
        ack_i[i] = 1'b1;
        tick();
        ack_i[i] = 1'b0;
        check($sformatf("u%0d_valid_after_ack", i), 32'(valid_o[i]), 32'd0);
    endtask

    task automatic run_op(input int i, input string tag, input logic [1:0] m,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        start(i, m, a, b);
        wait_done(i, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result_o[i], exp);
        do_ack(i);
    endtask

    initial begin
        int lat_tab [4];
        int pulses;
        lat_tab = '{8, 32, 16, 4};
        n_cmp = 0; n_err = 0;
        valid_i = '0; ack_i = '0; flush = 1'b0;
        mode = 2'b00; op1 = 32'h0; op2 = 32'h0;
        resetn = 1'b0;
        repeat (2) tick();
        check("reset_ready", 32'(ready_o[0]), 32'd1);
        check("reset_valid", 32'(valid_o[0]), 32'd0);
        check("reset_result", result_o[0], 32'h0);
        resetn = 1'b1;
        tick();

        run_op(0, "clmul_3x3", 2'b00, 32'h3, 32'h3, 32'h5, 8);
        run_op(0, "clmul_f0x3", 2'b00, 32'hF0, 32'h3, 32'h110, 8);
        run_op(0, "msb_clmul", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 8);
        run_op(0, "msb_clmulh", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8);
        run_op(0, "msb_clmulr", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 8);

        for (int i = 0; i < 4; i++) begin
            run_op(i, $sformatf("dense_l_u%0d", i), 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h5555_5555, lat_tab[i]);
            run_op(i, $sformatf("dense_h_u%0d", i), 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'h5555_5555, lat_tab[i]);
        end

        // Delayed ack: result held, and a request in the ack cycle must wait a cycle.
        begin
            int lat;
            start(0, 2'b00, 32'h3, 32'h3);
            wait_done(0, lat);
            check("hs_latency", 32'(lat), 32'd8);
            for (int r = 0; r < 5; r++) begin
                check($sformatf("hs_hold_result_%0d", r), result_o[0], 32'h5);
                check($sformatf("hs_hold_ready_%0d", r), 32'(ready_o[0]), 32'd0);
                check($sformatf("hs_hold_valid_%0d", r), 32'(valid_o[0]), 32'd1);
                tick();
            end
            ack_i[0] = 1'b1;
            valid_i[0] = 1'b1; mode = 2'b11; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF;
            tick();
            ack_i[0] = 1'b0;
            check("hs_valid_after_ack", 32'(valid_o[0]), 32'd0);
            check("hs_not_accepted_in_ack", 32'(ready_o[0]), 32'd1);
            tick();
            valid_i[0] = 1'b0;
            check("hs_accepted_next", 32'(ready_o[0]), 32'd0);
            wait_done(0, lat);
            check("rsvd_latency", 32'(lat), 32'd8);
            check("rsvd_result", result_o[0], 32'h0);
            do_ack(0);
        end

        // Flush during BUSY iteration 3.
        start(0, 2'b00, 32'h3, 32'h3);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", 32'(ready_o[0]), 32'd1);
        check("flush_valid", 32'(valid_o[0]), 32'd0);
        pulses = 0;
        for (int r = 0; r < 12; r++) begin
            if (valid_o[0]) pulses++;
            tick();
        end
        check("flush_no_pulse", 32'(pulses), 32'd0);
        run_op(0, "post_flush", 2'b00, 32'h3, 32'h3, 32'h5, 8);

        // Flush coincident with a request in IDLE.
        valid_i[0] = 1'b1; flush = 1'b1; op1 = 32'h3; op2 = 32'h3;
        tick();
        valid_i[0] = 1'b0; flush = 1'b0;
        check("flush_idle_not_accepted", 32'(ready_o[0]), 32'd1);
        pulses = 0;
        for (int r = 0; r < 12; r++) begin
            if (valid_o[0]) pulses++;
            tick();
        end
        check("flush_idle_no_pulse", 32'(pulses), 32'd0);

        // Asynchronous reset mid-operation; previous result 0x5 must be cleared.
        start(0, 2'b00, 32'h3, 32'h3);
        repeat (2) tick();
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_o[0]), 32'd1);
        check("rst_mid_valid", 32'(valid_o[0]), 32'd0);
        check("rst_mid_result", result_o[0], 32'h0);
        #3 resetn = 1'b1;
        tick();
        run_op(0, "post_reset", 2'b00, 32'h5, 32'h7, 32'h1B, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
